// File: rtl/usbf_tx_assembler_pkg.sv
// rtl/usbf_tx_assembler_pkg.sv - shared USB device definitions: PIDs, tx states, CRC16 constants
package usbf_defines;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY = 16'h8005;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PID  = 3'd1,
      ST_DATA = 3'd2,
      ST_CRC1 = 3'd3,
      ST_CRC2 = 3'd4
   } tx_state_t;

   function automatic logic [7:0] bit_rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

endpackage

// File: rtl/usbf_tx_assembler_crc16.sv
// rtl/usbf_tx_assembler_crc16.sv - CRC16 next state for one byte, MSB-first on bit-reversed data
module usbf_crc16
   import usbf_defines::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  din,
   output logic [15:0] crc_out
);

   logic [15:0] w_c;

   always_comb begin
      w_c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (w_c[15] ^ din[i]) w_c = {w_c[14:0], 1'b0} ^ CRC16_POLY;
         else                  w_c = {w_c[14:0], 1'b0};
      end
      crc_out = w_c;
   end

endmodule

// File: rtl/usbf_tx_assembler.sv
// rtl/usbf_tx_assembler.sv - USB device transmit packet assembler (handshake and data packets)
module usbf_tx_assembler
   import usbf_defines::*;
#(
   parameter int MAX_PL = 1024,
   parameter int CNT_W  = 11
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             pkt_type,
   input  logic [3:0]       pid,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [7:0]       rd_data,
   output logic             rd_next,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             tx_last,
   output logic             tx_first
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PL);

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   logic [3:0]       r_pid;
   logic             r_type;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_crc;
   logic             r_done;
   logic             r_err;
   logic             w_accept;
   logic             w_req_bad;
   logic             w_req_ok;
   logic [15:0]      w_crc_nxt;

   assign w_accept  = tx_valid & tx_ready;
   assign w_req_bad = req & pkt_type & (len > MAX_LEN);
   assign w_req_ok  = req & ~w_req_bad;

   // The core CRC engine works MSB-first, so USB's LSB-first byte order is fed reversed.
   usbf_crc16 u_crc16 (
      .crc_in  (r_crc),
      .din     (bit_rev8(rd_data)),
      .crc_out (w_crc_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_req_ok) w_state_nxt = ST_PID;
         ST_PID:
            if (tx_ready) begin
               if (!r_type)                 w_state_nxt = ST_IDLE;
               else if (r_cnt == '0)        w_state_nxt = ST_CRC1;
               else                         w_state_nxt = ST_DATA;
            end
         ST_DATA: if (tx_ready && r_cnt == CNT_W'(1)) w_state_nxt = ST_CRC1;
         ST_CRC1: if (tx_ready) w_state_nxt = ST_CRC2;
         ST_CRC2: if (tx_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = (r_state != ST_IDLE);
      tx_first = (r_state == ST_PID);
      tx_last  = ((r_state == ST_PID) && !r_type) || (r_state == ST_CRC2);
      rd_next  = (r_state == ST_DATA) && tx_ready;
      busy     = tx_valid;
      done     = r_done;
      err      = r_err;
      case (r_state)
         ST_PID:  tx_data = {~r_pid, r_pid};
         ST_DATA: tx_data = rd_data;
         // Wire CRC is the complemented, bit-reflected register, low byte first.
         ST_CRC1: tx_data = ~bit_rev8(r_crc[15:8]);
         ST_CRC2: tx_data = ~bit_rev8(r_crc[7:0]);
         default: tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pid  <= 4'h0;
         r_type <= 1'b0;
         r_cnt  <= '0;
         r_crc  <= CRC16_INIT;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_accept && ((r_state == ST_CRC2) || ((r_state == ST_PID) && !r_type));
         r_err  <= (r_state == ST_IDLE) && w_req_bad;
         if (r_state == ST_IDLE && w_req_ok) begin
            r_pid  <= pid;
            r_type <= pkt_type;
            r_cnt  <= len;
            r_crc  <= CRC16_INIT;
         end else if (r_state == ST_DATA && w_accept) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_crc <= w_crc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_usbf_tx_assembler.sv
// tb/tb_usbf_tx_assembler.sv - scoreboard bench for usbf_tx_assembler
module tb_usbf_tx_assembler;

   localparam int MAX_PL = 1024;
   localparam int CNT_W  = 11;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       l;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req = 1'b0;
   logic             pkt_type = 1'b0;
   logic [3:0]       pid = 4'h0;
   logic [CNT_W-1:0] len = '0;
   logic             busy, done, err, rd_next, tx_valid, tx_last, tx_first;
   logic [7:0]       rd_data, tx_data;
   logic             tx_ready = 1'b1;

   logic [7:0]  mem [0:2047];
   logic [10:0] rd_ptr = '0;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0, err_cnt = 0, rd_cnt = 0;
   int          exp_ptr = 0;
   int          rd0 = 0;
   bit          ready_mode = 0;

   usbf_tx_assembler #(.MAX_PL(MAX_PL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req(req), .pkt_type(pkt_type), .pid(pid), .len(len),
      .busy(busy), .done(done), .err(err), .rd_data(rd_data), .rd_next(rd_next),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .tx_first(tx_first)
   );

   always #5 clk = ~clk;

   assign rd_data = mem[rd_ptr];
   always @(posedge clk) if (rd_next) rd_ptr <= rd_ptr + 11'd1;

   initial forever begin
      @(posedge clk);
      #1;
      if (ready_mode) tx_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference CRC16-USB, reflected form, over bench buffer bytes
   function automatic logic [15:0] crc_model(input int base, input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, mem[(base + i) & 2047]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return ~c;
   endfunction

   // Monitor: pops the scoreboard on every accepted byte and checks stall stability
   initial begin
      exp_t        e;
      logic        stall_prev;
      logic [7:0]  held;
      stall_prev = 0;
      held = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_prev = 0;
         end else begin
            if (tx_valid && tx_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_byte actual=%02h expected=none", tx_data);
               end else begin
                  e = sb.pop_front();
                  if ({tx_data, tx_first, tx_last} !== e) begin
                     errors++;
                     $display("FAIL wire_byte actual=%02h/f%0b/l%0b expected=%02h/f%0b/l%0b",
                              tx_data, tx_first, tx_last, e.d, e.f, e.l);
                  end
               end
            end
            if (stall_prev && tx_valid) begin
               checks++;
               if (tx_data !== held) begin
                  errors++;
                  $display("FAIL stall_stable actual=%02h expected=%02h", tx_data, held);
               end
            end
            stall_prev = tx_valid && !tx_ready;
            held = tx_data;
            if (done)    done_cnt++;
            if (err)     err_cnt++;
            if (rd_next) rd_cnt++;
         end
      end
   end

   // keep < 0 queues the whole packet; otherwise only PID plus keep payload bytes
   task automatic start_pkt(input logic typ, input logic [3:0] p, input int n, input int keep);
      logic [15:0] c;
      int          m;
      sb.push_back('{d: {~p, p}, f: 1'b1, l: !typ});
      if (typ) begin
         m = (keep < 0) ? n : keep;
         for (int i = 0; i < m; i++) sb.push_back('{d: mem[(exp_ptr + i) & 2047], f: 1'b0, l: 1'b0});
         if (keep < 0) begin
            c = crc_model(exp_ptr, n);
            sb.push_back('{d: c[7:0],  f: 1'b0, l: 1'b0});
            sb.push_back('{d: c[15:8], f: 1'b0, l: 1'b1});
         end
         exp_ptr += m;
      end
      rd0 = rd_cnt;
      req = 1'b1; pkt_type = typ; pid = p; len = CNT_W'(n);
      @(posedge clk);
      #1;
      req = 1'b0;
      chk("busy_after_req", busy, 1'b1);
   endtask

   task automatic wait_done(input int exp_cyc);
      int cyc;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 5000);
      if (!done) chk("done_timeout", 0, 1);
      else if (exp_cyc > 0) chk("pkt_cycles", cyc, exp_cyc);
   endtask

   task automatic finish_pkt(input int n_rd);
      @(posedge clk);
      #1;
      chk("done_width", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("sb_empty", sb.size(), 0);
      chk("rd_next_count", rd_cnt - rd0, n_rd);
   endtask

   initial begin
      int e0;
      mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
      for (int i = 4; i < 2048; i++) mem[i] = 8'($urandom);

      #3;
      chk("rst_outputs", {busy, done, err, rd_next, tx_valid, tx_last, tx_first, tx_data}, 15'h0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;

      // ACK handshake
      start_pkt(1'b0, 4'h2, 0, -1);
      chk("ack_byte", tx_data, 8'hD2);
      chk("ack_flags", {tx_first, tx_last}, 2'b11);
      wait_done(1);
      finish_pkt(0);

      // zero-length DATA0
      start_pkt(1'b1, 4'h3, 0, -1);
      chk("data0_pid", tx_data, 8'hC3);
      wait_done(3);
      finish_pkt(0);

      // DATA1 len 4, payload 00 01 02 03
      start_pkt(1'b1, 4'hB, 4, -1);
      chk("data1_pid", tx_data, 8'h4B);
      wait_done(7);
      finish_pkt(4);

      // max length with random back-pressure
      ready_mode = 1;
      start_pkt(1'b1, 4'h3, MAX_PL, -1);
      wait_done(0);
      ready_mode = 0;
      tx_ready = 1'b1;
      finish_pkt(MAX_PL);

      // oversize request
      e0 = err_cnt;
      req = 1'b1; pkt_type = 1'b1; pid = 4'h3; len = CNT_W'(MAX_PL + 1);
      @(posedge clk); #1; req = 1'b0;
      chk("err_pulse", err, 1'b1);
      chk("err_busy", busy, 1'b0);
      chk("err_tx_valid", tx_valid, 1'b0);
      @(posedge clk); #1;
      chk("err_clear", err, 1'b0);
      chk("err_count", err_cnt - e0, 1);
      chk("err_still_idle", tx_valid, 1'b0);

      // req while busy is ignored
      start_pkt(1'b1, 4'hB, 4, -1);
      @(posedge clk); #1;
      req = 1'b1; pkt_type = 1'b0; pid = 4'hA;
      @(posedge clk); #1; req = 1'b0;
      wait_done(0);
      finish_pkt(4);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_req_ignored", tx_valid, 1'b0);

      // back to back: NAK requested in ACK's done cycle
      start_pkt(1'b0, 4'h2, 0, -1);
      wait_done(1);
      start_pkt(1'b0, 4'hA, 0, -1);
      chk("b2b_nak_byte", tx_data, 8'h5A);
      wait_done(1);
      finish_pkt(0);

      // reset in DATA after two payload bytes
      start_pkt(1'b1, 4'h3, 8, 2);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_outs", {busy, rd_next, tx_last, tx_first, tx_data}, 12'h0);
      chk("rst_rd_count", rd_cnt - rd0, 2);
      chk("rst_sb_empty", sb.size(), 0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      start_pkt(1'b0, 4'h2, 0, -1);
      chk("post_rst_ack", tx_data, 8'hD2);
      wait_done(1);
      finish_pkt(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/usbf_tx_assembler.md
# usbf_tx_assembler

Parametrised USB device transmit packet assembler between the protocol engine and the UTMI transmit port. It builds handshake packets (PID only) and data packets (PID, length-counted payload pulled from the IDMA buffer, CRC16) from a single request, including zero-length packets. Payload length is bounded by a parameter, and it signals completion and error back to the protocol engine.

## Interface
- MAX_PL, default 1024: largest payload in bytes; legal range 1..1024.
- CNT_W, default 11: width of the length and count fields; must satisfy 2^CNT_W > MAX_PL.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  start pulse; sampled only in IDLE.
- pkt_type  in  1  0 = handshake, 1 = data.
- pid  in  4  PID code; sent on the wire as byte {~pid, pid}.
- len  in  CNT_W  payload byte count for data packets; 0 means a zero-length packet.
- busy  out  1  high from the cycle after an accepted req until the packet ends.
- done  out  1  one-cycle pulse after the final byte is accepted.
- err  out  1  one-cycle pulse when req is rejected because len > MAX_PL.
- rd_data  in  8  current payload byte from the first-word-fall-through buffer.
- rd_next  out  1  pops rd_data; asserted when a payload byte is accepted.
- tx_data  out  8  UTMI transmit byte.
- tx_valid  out  1  UTMI TxValid.
- tx_ready  in  1  UTMI TxReady.
- tx_last  out  1  high while the final byte of the packet is presented.
- tx_first  out  1  high while the PID byte is presented.

## Operation
- States: IDLE, PID, DATA, CRC1, CRC2.
- Byte acceptance: a byte is accepted on any edge where tx_valid and tx_ready are both high. tx_data is held stable until the byte is accepted.
- IDLE, req with len ≤ MAX_PL (or pkt_type = 0): latch pid, pkt_type and len, load the remaining-byte counter with len, set crc to 16'hFFFF, go to PID.
- IDLE, req with pkt_type = 1 and len > MAX_PL: pulse err on the next cycle and stay in IDLE.
- PID: tx_data = {~pid, pid}. On accept:
  - handshake → IDLE;
  - data with len = 0 → CRC1;
  - otherwise → DATA.
- DATA: tx_data = rd_data and rd_next = tx_ready. On each accept:
  - crc ← crc16(crc, rd_data);
  - remaining counter decrements;
  - when the accept consumes the last byte (remaining = 1) → CRC1.
- CRC1: tx_data = ~crc reflected, low byte. On accept → CRC2.
- CRC2: tx_data = ~crc reflected, high byte. On accept → IDLE.
- tx_last is high in PID for handshakes and in CRC2 for data packets. tx_first is high in PID only.
- busy = (state != IDLE).
- done is a registered pulse, set on the edge that leaves CRC2, or leaves PID for a handshake.
- req while busy is ignored; no queueing.
- In IDLE, tx_data = 8'h00.
- Reset mid-packet: everything returns immediately to IDLE with all outputs at reset values. The buffer is not flushed; flushing is the owner's responsibility.

## Timing
- Reset values: busy 0, done 0, err 0, rd_next 0, tx_valid 0, tx_last 0, tx_first 0, tx_data 8'h00. Internal crc resets to FFFF and the counter to 0.
- Latency: req at edge n puts the PID on tx_data with tx_valid high after edge n. The PID can be accepted at edge n+1 at the earliest.
- tx_valid = (state != IDLE), decoded from the state register with no combinational path from inputs. rd_next is combinational from tx_ready in DATA only.
- Packet length on the wire: handshake 1 byte; data packet len + 3 bytes. With tx_ready held high this takes len + 3 cycles, then done on the following cycle.
- tx_ready low stalls any state indefinitely. The counter and crc change only on accepts.
- A new req is accepted in the cycle where done is high; the packets are back to back.

## Structure
- The shared package usbf_defines holds the PID constants, the state encodings, and the CRC16 init value (FFFF) and polynomial (8005, reflected).
- One sub-module: the existing usbf_crc16 combinational next-state function, fed bit-reversed rd_data as in the current transmit path.
- Everything else lives in one module: the state register, the counter, the crc register and the output mux.

## Test plan
- Handshake ACK (pid 4'h2) with tx_ready high: single byte D2 with tx_last and tx_first high; done pulses two cycles after req.
- Zero-length DATA0 (pid 4'h3, len 0): wire bytes C3 00 00; rd_next never asserts; tx_last only on the third byte.
- DATA1 with len 4, payload 00 01 02 03: wire bytes 4B 00 01 02 03 followed by two CRC bytes equal to the bench software CRC16 model; exactly 4 rd_next pulses.
- Random tx_ready (≈50% duty) on a len = MAX_PL packet: no byte lost or duplicated, tx_data stable while stalled, CRC correct.
- Request errors and back-to-back traffic:
  - len = MAX_PL+1 data req: err pulses once, busy stays 0, tx_valid stays 0;
  - req during busy: ignored;
  - req in the done cycle: the next packet starts.
- rst asserted in DATA after 2 bytes: tx_valid falls the same cycle. After release, an ACK handshake goes out correctly.
